// File: rtl/four_input_and_gate_b.sv
// Four-input AND as a two-level tree of 2-input ANDs, all three nodes registered.
// Latency: 1 clk from input sample to e/f/g. Backpressure: none, new result every cycle.
// Optional FOUR_AND_HIT_CNT_EN adds g_cnt, a 16-bit saturating count of cycles with g high.
module four_input_and_gate_b (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  output logic        e,
  output logic        f,
  output logic        g
`ifdef FOUR_AND_HIT_CNT_EN
  ,
  output logic [15:0] g_cnt
`endif
);

  logic e_next;
  logic f_next;
  logic g_next;

  // g is built from the same-cycle partial products, so g == e & f on every cycle.
  always_comb begin
    e_next = a & b;
    f_next = c & d;
    g_next = e_next & f_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e <= 1'b0;
      f <= 1'b0;
      g <= 1'b0;
    end else begin
      e <= e_next;
      f <= f_next;
      g <= g_next;
    end
  end

`ifdef FOUR_AND_HIT_CNT_EN
  // Counts the registered g, so a hit shows up in g_cnt one edge after g rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_cnt <= 16'h0000;
    end else if (g && (g_cnt != 16'hFFFF)) begin
      g_cnt <= g_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_four_input_and_gate_b.sv
// Directed bench for four_input_and_gate_b with a queue-based scoreboard.
module tb_four_input_and_gate_b;

  logic        clk;
  logic        rst;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        e;
  logic        f;
  logic        g;
  logic [15:0] g_cnt_obs;
`ifdef FOUR_AND_HIT_CNT_EN
  logic [15:0] g_cnt;
`endif

  typedef struct {
    logic [2:0]  efg;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int misses  = 0;
  int g_hits  = 0;

  logic        m_g;
  logic [15:0] m_cnt;

  four_input_and_gate_b dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .e    (e),
    .f    (f),
    .g    (g)
`ifdef FOUR_AND_HIT_CNT_EN
    ,
    .g_cnt(g_cnt)
`endif
  );

`ifdef FOUR_AND_HIT_CNT_EN
  assign g_cnt_obs = g_cnt;
`else
  assign g_cnt_obs = 16'h0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector, push its expected result, clock it and check it.
  task automatic step(input logic ir, input logic ia, input logic ib,
                      input logic ic, input logic id);
    exp_t ex;
    exp_t got;
    logic xe;
    logic xf;
    logic xg;
    rst = ir;
    a   = ia;
    b   = ib;
    c   = ic;
    d   = id;
    xe = ir ? 1'b0 : (ia & ib);
    xf = ir ? 1'b0 : (ic & id);
    xg = ir ? 1'b0 : (ia & ib & ic & id);
    ex.efg = {xe, xf, xg};
    if (ir)
      ex.cnt = 16'h0000;
    else if ((m_g === 1'b1) && (m_cnt != 16'hFFFF))
      ex.cnt = m_cnt + 16'd1;
    else
      ex.cnt = m_cnt;
`ifndef FOUR_AND_HIT_CNT_EN
    ex.cnt = 16'h0000;
`endif
    m_g   = xg;
    m_cnt = ex.cnt;
    q.push_back(ex);
    @(posedge clk);
    #1;
    got = q.pop_front();
    vectors++;
    if (g === 1'b1) g_hits++;
    assert ({e, f, g} === got.efg)
    else begin
      misses++;
      $error("FAIL efg vec=%0d observed=%b expected=%b", vectors, {e, f, g}, got.efg);
    end
    assert (g_cnt_obs === got.cnt)
    else begin
      misses++;
      $error("FAIL g_cnt vec=%0d observed=%h expected=%h", vectors, g_cnt_obs, got.cnt);
    end
  endtask

  initial begin
    m_g   = 1'b0;
    m_cnt = 16'h0000;
    rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;

    // Reset held for two edges with all operands high.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Exhaustive sweep of {d,c,b,a}.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step(1'b0, v[0], v[1], v[2], v[3]);
    end

    // Partial products in isolation.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Known 0 dominates an X operand.
    step(1'b0, 1'bx, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Free-running toggles: a every cycle, b every 2, c every 4, d every 8.
    g_hits = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step(1'b0, v[0], v[1], v[2], v[3]);
    end
    vectors++;
    assert (g_hits == 1)
    else begin
      misses++;
      $error("FAIL toggle_g_hits observed=%0d expected=1", g_hits);
    end

    // Reset mid-run with all operands high.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

`ifdef FOUR_AND_HIT_CNT_EN
    // Saturation: long run with all operands high.
    for (int i = 0; i < 70000; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    vectors++;
    assert (g_cnt === 16'hFFFF)
    else begin
      misses++;
      $error("FAIL g_cnt_saturated observed=%h expected=ffff", g_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
